// File: rtl/aes_pkg.sv
// Shared AES types, constants and byte-level helpers for the round datapath.
package aes_pkg;

    localparam int unsigned LARGURA_BYTE   = 8;
    localparam int unsigned LARGURA_COLUNA = 32;
    localparam int unsigned LARGURA_ESTADO = 128;
    localparam int unsigned NUM_COLUNAS    = 4;

    localparam logic [7:0] AES_POLI = 8'h1b;

    typedef enum logic [1:0] {
        OCIOSO    = 2'd0,
        CALCULA   = 2'd1,
        CONCLUIDO = 2'd2
    } estado_fsm_t;

    // Multiply by x in GF(2^8), reduced by the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLI : 8'h00);
    endfunction

    // Column-major byte position of s[r][c]; byte 0 sits in the MSBs.
    function automatic int unsigned indice_byte(input int unsigned r, input int unsigned c);
        return NUM_COLUNAS * c + r;
    endfunction

    // Row r rotates left by r positions: s'[r][c] = s[r][(c+r) mod 4].
    function automatic logic [LARGURA_ESTADO-1:0] shift_rows(input logic [LARGURA_ESTADO-1:0] s);
        logic [LARGURA_ESTADO-1:0] o;
        o = '0;
        for (int unsigned r = 0; r < 4; r++) begin
            for (int unsigned c = 0; c < NUM_COLUNAS; c++) begin
                o[127 - 8*indice_byte(r, c) -: 8] = s[127 - 8*indice_byte(r, (c + r) % 4) -: 8];
            end
        end
        return o;
    endfunction

endpackage

// File: rtl/desloca_mistura_seq_if.sv
// Upstream capture and downstream delivery handshakes of the stage.
interface desloca_mistura_seq_if;
    logic         entrada_valida;
    logic         entrada_pronta;
    logic [127:0] bloco;
    logic         ultima_rodada;
    logic         saida_valida;
    logic         saida_pronta;
    logic [127:0] saida;

    modport slave (
        input  entrada_valida, bloco, ultima_rodada, saida_pronta,
        output entrada_pronta, saida_valida, saida
    );

    modport master (
        output entrada_valida, bloco, ultima_rodada, saida_pronta,
        input  entrada_pronta, saida_valida, saida
    );
endinterface

// File: rtl/mistura_coluna.sv
// Combinational MixColumns on a single 32-bit column; a0 is the top byte.
module mistura_coluna
    import aes_pkg::*;
(
    input  logic [LARGURA_COLUNA-1:0] coluna,
    output logic [LARGURA_COLUNA-1:0] misturada
);

    logic [7:0] a0, a1, a2, a3;
    logic [7:0] d0, d1, d2, d3;
    logic [7:0] t0, t1, t2, t3;

    assign a0 = coluna[31:24];
    assign a1 = coluna[23:16];
    assign a2 = coluna[15:8];
    assign a3 = coluna[7:0];

    // Doubled and tripled bytes feeding the fixed MixColumns matrix.
    assign d0 = xtime(a0);
    assign d1 = xtime(a1);
    assign d2 = xtime(a2);
    assign d3 = xtime(a3);
    assign t0 = d0 ^ a0;
    assign t1 = d1 ^ a1;
    assign t2 = d2 ^ a2;
    assign t3 = d3 ^ a3;

    assign misturada = {d0 ^ t1 ^ a2 ^ a3,
                        a0 ^ d1 ^ t2 ^ a3,
                        a0 ^ a1 ^ d2 ^ t3,
                        t0 ^ a1 ^ a2 ^ d3};

endmodule

// File: rtl/desloca_mistura_seq.sv
// ShiftRows on capture, then iterative MixColumns over L = 4/K cycles.
module desloca_mistura_seq
    import aes_pkg::*;
#(
    parameter int unsigned COLUNAS_POR_CICLO = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    desloca_mistura_seq_if.slave   barramento
);

    localparam int unsigned K        = COLUNAS_POR_CICLO;
    localparam int unsigned L        = NUM_COLUNAS / K;
    localparam logic [1:0]  CONT_FIM = 2'(L - 1);

    estado_fsm_t               state_q, state_d;
    logic [LARGURA_ESTADO-1:0] estado;
    logic [1:0]                contador;
    logic                      ultima;

    logic [1:0]                indice    [K];
    logic [LARGURA_COLUNA-1:0] misturada [K];

    // One mixer per column handled in a CALCULA cycle.
    for (genvar j = 0; j < int'(K); j++) begin : g_col
        assign indice[j] = 2'(int'(contador) * int'(K) + j);
        mistura_coluna u_mistura (
            .coluna    (estado[127 - 32*indice[j] -: 32]),
            .misturada (misturada[j])
        );
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= OCIOSO;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            OCIOSO:    if (barramento.entrada_valida) state_d = CALCULA;
            CALCULA:   if (contador == CONT_FIM)      state_d = CONCLUIDO;
            CONCLUIDO: if (barramento.saida_pronta)   state_d = OCIOSO;
            default:                                  state_d = OCIOSO;
        endcase
    end

    // Handshake flags decoded from the state register only.
    always_comb begin
        barramento.entrada_pronta = 1'b0;
        barramento.saida_valida   = 1'b0;
        unique case (state_q)
            OCIOSO:    barramento.entrada_pronta = 1'b1;
            CONCLUIDO: barramento.saida_valida   = 1'b1;
            default: ;
        endcase
    end

    // Datapath: capture with ShiftRows, then mix K columns per cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado   <= '0;
            contador <= '0;
            ultima   <= 1'b0;
        end else begin
            unique case (state_q)
                OCIOSO: begin
                    if (barramento.entrada_valida) begin
                        estado   <= shift_rows(barramento.bloco);
                        ultima   <= barramento.ultima_rodada;
                        contador <= '0;
                    end
                end
                CALCULA: begin
                    contador <= contador + 2'd1;
                    if (!ultima) begin
                        for (int j = 0; j < int'(K); j++) begin
                            estado[127 - 32*indice[j] -: 32] <= misturada[j];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign barramento.saida = estado;

endmodule

// File: tb/tb_desloca_mistura_seq.sv
// Directed bench: three instances (K=1,2,4) share stimulus and are checked per instance.
module tb_desloca_mistura_seq;

    typedef struct {
        string        nome;
        logic [127:0] bloco;
        logic         ultima;
        logic [127:0] esperado;
    } vetor_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         ev, ur, sp;
    logic [127:0] bl;

    int testes = 0;
    int falhas = 0;

    desloca_mistura_seq_if if0 ();
    desloca_mistura_seq_if if1 ();
    desloca_mistura_seq_if if2 ();

    assign if0.entrada_valida = ev; assign if0.bloco = bl; assign if0.ultima_rodada = ur; assign if0.saida_pronta = sp;
    assign if1.entrada_valida = ev; assign if1.bloco = bl; assign if1.ultima_rodada = ur; assign if1.saida_pronta = sp;
    assign if2.entrada_valida = ev; assign if2.bloco = bl; assign if2.ultima_rodada = ur; assign if2.saida_pronta = sp;

    desloca_mistura_seq #(.COLUNAS_POR_CICLO(1)) dut1 (.clk(clk), .rst_n(rst_n), .barramento(if0));
    desloca_mistura_seq #(.COLUNAS_POR_CICLO(2)) dut2 (.clk(clk), .rst_n(rst_n), .barramento(if1));
    desloca_mistura_seq #(.COLUNAS_POR_CICLO(4)) dut4 (.clk(clk), .rst_n(rst_n), .barramento(if2));

    logic         sv [3];
    logic         ep [3];
    logic [127:0] so [3];
    assign sv[0] = if0.saida_valida;   assign sv[1] = if1.saida_valida;   assign sv[2] = if2.saida_valida;
    assign ep[0] = if0.entrada_pronta; assign ep[1] = if1.entrada_pronta; assign ep[2] = if2.entrada_pronta;
    assign so[0] = if0.saida;          assign so[1] = if1.saida;          assign so[2] = if2.saida;

    int lat_esp [3] = '{4, 2, 1};

    always #5 clk = ~clk;

    task automatic chk(input string nome, input logic [127:0] atual, input logic [127:0] exigido);
        testes++;
        if (atual !== exigido) begin
            falhas++;
            $display("FAIL %s: got %h expected %h", nome, atual, exigido);
        end
    endtask

    // Handshake one block into all instances; leaves them in CONCLUIDO with sp=0.
    task automatic enviar(input vetor_t v);
        int lat [3];
        @(negedge clk);
        ev = 1'b1; bl = v.bloco; ur = v.ultima; sp = 1'b0;
        @(posedge clk); #1;
        ev = 1'b0;
        chk({v.nome, " busy_pronta"}, 128'(ep[0]), 128'(0));
        lat = '{0, 0, 0};
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            for (int d = 0; d < 3; d++)
                if (lat[d] == 0 && sv[d] === 1'b1) lat[d] = k;
        end
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s lat_k%0d", v.nome, d), 128'(lat[d]), 128'(lat_esp[d]));
            chk($sformatf("%s saida_k%0d", v.nome, d), so[d], v.esperado);
        end
    endtask

    task automatic liberar(input string nome);
        @(negedge clk); sp = 1'b1;
        @(posedge clk); #1; sp = 1'b0;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s release_valida_k%0d", nome, d), 128'(sv[d]), 128'(0));
            chk($sformatf("%s release_pronta_k%0d", nome, d), 128'(ep[d]), 128'(1));
        end
    endtask

    vetor_t tabela [5];

    initial begin
        logic [127:0] retida;
        tabela[0] = '{"r1",     128'hd42711aee0bf98f1b8b45de51e415230, 1'b0, 128'h046681e5e0cb199a48f8d37a2806264c};
        tabela[1] = '{"last",   128'he9098972cb31075f3d327d94af2e2cb5, 1'b1, 128'he9317db5cb322c723d2e895faf090794};
        tabela[2] = '{"r2",     128'h49ded28945db96f17f39871a7702533b, 1'b0, 128'h584dcaf11b4b5aacdbe7caa81b6bb0e5};
        tabela[3] = '{"r1last", 128'hd42711aee0bf98f1b8b45de51e415230, 1'b1, 128'hd4bf5d30e0b452aeb84111f11e2798e5};
        tabela[4] = '{"zero",   128'h0,                               1'b0, 128'h0};

        rst_n = 1'b0; ev = 1'b0; ur = 1'b0; sp = 1'b0; bl = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset_pronta_k%0d", d), 128'(ep[d]), 128'(1));
            chk($sformatf("reset_valida_k%0d", d), 128'(sv[d]), 128'(0));
            chk($sformatf("reset_saida_k%0d", d), so[d], 128'(0));
        end

        // Table-driven vectors across all three column widths.
        for (int i = 0; i < 5; i++) begin
            enviar(tabela[i]);
            liberar(tabela[i].nome);
        end

        // Backpressure: result held, second block refused until release.
        enviar(tabela[0]);
        @(negedge clk);
        ev = 1'b1; bl = tabela[2].bloco; ur = 1'b0;
        retida = so[0];
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            chk("bp_saida", so[0], tabela[0].esperado);
            chk("bp_valida", 128'(sv[0]), 128'(1));
            chk("bp_pronta", 128'(ep[0]), 128'(0));
        end
        chk("bp_stable", so[0], retida);
        @(negedge clk); sp = 1'b1;
        @(posedge clk); #1; sp = 1'b0;
        chk("bp_back_idle", 128'(ep[0]), 128'(1));
        chk("bp_valida_low", 128'(sv[0]), 128'(0));
        @(posedge clk); #1; ev = 1'b0;
        chk("bp_captured", 128'(ep[0]), 128'(0));
        repeat (4) @(posedge clk); #1;
        chk("bp_second_valida", 128'(sv[0]), 128'(1));
        chk("bp_second_saida", so[0], tabela[2].esperado);
        liberar("bp");

        // Reset while the K=1 instance is at contador=2.
        @(negedge clk); ev = 1'b1; bl = tabela[0].bloco; ur = 1'b0;
        @(posedge clk); #1; ev = 1'b0;
        repeat (2) @(posedge clk); #1;
        chk("mid_busy_valida", 128'(sv[0]), 128'(0));
        @(negedge clk); rst_n = 1'b0;
        @(posedge clk); #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("mid_rst_valida_k%0d", d), 128'(sv[d]), 128'(0));
            chk($sformatf("mid_rst_saida_k%0d", d), so[d], 128'(0));
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_pronta", 128'(ep[0]), 128'(1));
        enviar(tabela[0]);
        liberar("post_rst");

        $display("[TB] %0d tests run, %0d failed", testes, falhas);
        $finish;
    end

endmodule

// File: doc/desloca_mistura_seq.md
Name: desloca_mistura_seq

Overview:
Registered ShiftRows plus iterative MixColumns stage. It sits directly downstream of substituiBytes in the AES round datapath. It accepts one 128-bit state per valid/ready handshake and applies ShiftRows on capture. It then applies MixColumns to COLUNAS_POR_CICLO columns per cycle and holds the result until the downstream stage (AddRoundKey) accepts it. Last round: MixColumns is bypassed and the latency is unchanged.

Parameters:
COLUNAS_POR_CICLO, 1, columns mixed per CALCULA cycle; legal values 1, 2, 4; latency L = 4/COLUNAS_POR_CICLO.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
entrada_valida  input  1  bloco/ultima_rodada valid
entrada_pronta  output  1  stage can accept; high only in OCIOSO
bloco  input  128  SubBytes output; byte i = bloco[127-8i -: 8]; column-major, s[r][c] = byte 4c+r
ultima_rodada  input  1  1 = skip MixColumns (final AES round)
saida_valida  output  1  saida holds a finished state
saida_pronta  input  1  downstream accepts
saida  output  128  ShiftRows(+MixColumns) result, same byte ordering as bloco

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n; it is sampled only at the clk rising edge.
- Reset (rst_n=0 at edge), also when applied mid-operation:
  - state goes to OCIOSO; estado=0; contador=0; ultima=0.
  - saida_valida=0 and saida=0 from the next cycle; entrada_pronta=1 after rst_n is released.
  - Any in-flight block is discarded.
- FSM states: OCIOSO, CALCULA, CONCLUIDO.
- OCIOSO:
  - entrada_pronta=1, saida_valida=0.
  - On an edge with entrada_valida=1: estado <= ShiftRows(bloco), i.e. s'[r][c] = s[r][(c+r) mod 4]. Also ultima <= ultima_rodada, contador <= 0, go to CALCULA.
- CALCULA:
  - Each cycle, columns contador*K .. contador*K+K-1 (K=COLUNAS_POR_CICLO) are replaced by MixColumn(column), or left unchanged if ultima=1.
  - contador increments by 1 per cycle. After the cycle with contador=L-1, go to CONCLUIDO.
  - entrada_valida is ignored while not in OCIOSO.
- CONCLUIDO:
  - saida_valida=1; saida=estado, stable.
  - On an edge with saida_pronta=1, go to OCIOSO; saida_valida=0 on the next cycle.
  - If saida_pronta stays low, hold indefinitely.
- Latency: input handshake at edge N gives saida_valida=1 after edge N+L (L=4 for default). Minimum initiation interval is L+2 cycles; there is no overlap of blocks.
- MixColumn arithmetic, GF(2^8):
  - xtime(b) = {b[6:0],0} ^ (b[7] ? 8'h1b : 0).
  - Output column: o0=2a0^3a1^a2^a3, o1=a0^2a1^3a2^a3, o2=a0^a1^2a2^3a3, o3=3a0^a1^a2^2a3, where 3a = xtime(a)^a.
- saida is driven directly from the estado register, with no combinational path from bloco.
- entrada_pronta and saida_valida are decoded only from the state register.

Decomposition:
- Package aes_pkg:
  - state enum (OCIOSO, CALCULA, CONCLUIDO)
  - xtime function
  - shift_rows 128-bit function
  - constant 8'h1b (AES_POLI)
  - byte-index helper
- Sub-module mistura_coluna: combinational, 32-bit column in / 32-bit out. Instantiated COLUNAS_POR_CICLO times; reused by the later inverse/round blocks.

Test Plan:
- Idle after reset → entrada_pronta=1, saida_valida=0, saida=0.
- FIPS-197 round 1 (ultima_rodada=0): bloco=d42711aee0bf98f1b8b45de51e415230 → saida_valida exactly 4 cycles after the input handshake (L=4), saida=046681e5e0cb199a48f8d37a2806264c.
- Last round (ultima_rodada=1): bloco=e9098972cb31075f3d327d94af2e2cb5 → saida=e9317db5cb322c723d2e895faf090794 with the same 4-cycle latency.
- Backpressure: hold saida_pronta=0 for 10 cycles in CONCLUIDO, with entrada_valida=1 and a different bloco → saida stable, entrada_pronta=0, second block not captured. Then saida_pronta=1 → OCIOSO, then the second block is accepted.
- Reset mid-CALCULA (rst_n=0 at contador=2) → next cycle in OCIOSO, saida_valida=0, saida=0. A fresh round-1 vector afterwards gives the correct result.
- Parameter sweep: COLUNAS_POR_CICLO=2 and =4 with the round-1 vector → same saida, latency 2 and 1 cycles respectively.
